eth_tx_sched: RTL and testbench

Transmit frame scheduler for the RGMII transmit path, clocked in the 125 MHz Ethernet domain. Arbitrates two frame sources (requester 0: UART bridge frame buffer; requester 1: periodic status/heartbeat generator) and sequences the winning frame onto the byte stream feeding the RGMII DDR serializer in `tx_phy`. The per-frame sequence is: preamble, SFD, payload, zero padding to the minimum frame size, optional FCS, then inter-frame gap.

---
 rtl/eth_tx_sched_pkg.sv | 34 +++
 rtl/crc32_d8.sv | 20 ++
 rtl/eth_tx_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_eth_tx_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_sched_pkg.sv
// Shared types and constants for the RGMII transmit frame scheduler.
// The state set depends on ETH_TX_FCS_EN (FCS state present only when defined).
package eth_tx_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_PAD,
`ifdef ETH_TX_FCS_EN
        S_FCS,
`endif
        S_IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [7:0]  PAD_BYTE      = 8'h00;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam int unsigned FCS_BYTES     = 4;

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32 accumulator; clr reloads the initial value.
module crc32_d8
    import eth_tx_sched_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, data);
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Two-requester round-robin transmit frame scheduler feeding the RGMII serializer.
// Define ETH_TX_FCS_EN to append a generated CRC-32 FCS after payload and padding.
module eth_tx_sched
    import eth_tx_sched_pkg::*;
#(
    parameter int unsigned LEN_W          = 11,
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned MIN_PAYLOAD    = 60,
    parameter int unsigned MAX_PAYLOAD    = 1500,
    parameter int unsigned IFG_BYTES      = 12
) (
    input  logic             CLK125,
    input  logic             RST,
    input  logic [1:0]       REQ,
    input  logic [LEN_W-1:0] LEN0,
    input  logic [LEN_W-1:0] LEN1,
    input  logic [7:0]       DATA0,
    input  logic [7:0]       DATA1,
    output logic [1:0]       GNT,
    output logic [1:0]       RD,
    output logic [7:0]       TXD,
    output logic             TXEN,
    output logic             BUSY,
    output logic             FRAME_DONE
);

    localparam int unsigned CNT_MAX = (PREAMBLE_BYTES > IFG_BYTES) ? PREAMBLE_BYTES : IFG_BYTES;
    localparam int unsigned CNT_W   = $clog2(((CNT_MAX > FCS_BYTES) ? CNT_MAX : FCS_BYTES) + 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] pos_q, pos_d;
    logic             sel_q, sel_d;
    logic             rr_q, rr_d;
    logic [7:0]       txd_d;
    logic             txen_d, busy_d, done_d;
    logic [1:0]       gnt_d, rd_d;
    logic             win_c, tail_c, to_ifg_c;
    logic [LEN_W-1:0] req_len_c;
    logic [7:0]       data_c;
    logic [1:0]       rd_sel_c;

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q;
    logic [31:0] fcs_c;
    logic        crc_en_c;

    // Every cycle that loads a new payload/pad byte into TXD also folds it into the CRC.
    assign crc_en_c = (state_d == S_DATA) || (state_d == S_PAD);
    assign fcs_c    = ~crc_q;

    crc32_d8 u_crc (
        .clk  (CLK125),
        .clr  (state_q == S_IDLE),
        .en   (crc_en_c),
        .data (txd_d),
        .crc  (crc_q)
    );
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        rem_d     = rem_q;
        pos_d     = pos_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        txd_d     = PAD_BYTE;
        txen_d    = 1'b0;
        gnt_d     = 2'b00;
        rd_d      = 2'b00;
        done_d    = 1'b0;
        tail_c    = 1'b0;
        to_ifg_c  = 1'b0;
        win_c     = rr_q ? REQ[1] : ~REQ[0];
        req_len_c = win_c ? LEN1 : LEN0;
        data_c    = sel_q ? DATA1 : DATA0;
        rd_sel_c  = sel_q ? 2'b10 : 2'b01;

        case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    sel_d   = win_c;
                    rr_d    = ~win_c;
                    gnt_d   = win_c ? 2'b10 : 2'b01;
                    len_d   = (req_len_c > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : req_len_c;
                    pos_d   = '0;
                    cnt_d   = CNT_W'(1);
                    txd_d   = PREAMBLE_BYTE;
                    txen_d  = 1'b1;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                txen_d = 1'b1;
                if (cnt_q == CNT_W'(PREAMBLE_BYTES)) begin
                    txd_d   = SFD_BYTE;
                    state_d = S_SFD;
                    rem_d   = '0;
                    if (len_q != '0) begin
                        rd_d  = rd_sel_c;
                        rem_d = len_q - LEN_W'(1);
                    end
                end else begin
                    txd_d = PREAMBLE_BYTE;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SFD: begin
                txen_d = 1'b1;
                pos_d  = LEN_W'(1);
                if (len_q != '0) begin
                    txd_d   = data_c;
                    state_d = S_DATA;
                    if (rem_q != '0) begin
                        rd_d  = rd_sel_c;
                        rem_d = rem_q - LEN_W'(1);
                    end
                end else begin
                    state_d = S_PAD;
                end
            end
            S_DATA: begin
                if (pos_q != len_q) begin
                    txen_d = 1'b1;
                    txd_d  = data_c;
                    pos_d  = pos_q + LEN_W'(1);
                    if (rem_q != '0) begin
                        rd_d  = rd_sel_c;
                        rem_d = rem_q - LEN_W'(1);
                    end
                end else if (pos_q < LEN_W'(MIN_PAYLOAD)) begin
                    txen_d  = 1'b1;
                    pos_d   = pos_q + LEN_W'(1);
                    state_d = S_PAD;
                end else begin
                    tail_c = 1'b1;
                end
            end
            S_PAD: begin
                if (pos_q < LEN_W'(MIN_PAYLOAD)) begin
                    txen_d = 1'b1;
                    pos_d  = pos_q + LEN_W'(1);
                end else begin
                    tail_c = 1'b1;
                end
            end
`ifdef ETH_TX_FCS_EN
            S_FCS: begin
                if (cnt_q == CNT_W'(FCS_BYTES)) begin
                    to_ifg_c = 1'b1;
                end else begin
                    txen_d = 1'b1;
                    txd_d  = 8'(fcs_c >> {cnt_q[1:0], 3'b000});
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_IFG: begin
                if (cnt_q == CNT_W'(IFG_BYTES)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    done_d = ((cnt_q + CNT_W'(1)) == CNT_W'(IFG_BYTES));
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Payload and padding finished: FCS bytes (if built in) then the gap.
        if (tail_c) begin
`ifdef ETH_TX_FCS_EN
            txen_d  = 1'b1;
            txd_d   = fcs_c[7:0];
            cnt_d   = CNT_W'(1);
            state_d = S_FCS;
`else
            to_ifg_c = 1'b1;
`endif
        end
        if (to_ifg_c) begin
            cnt_d   = CNT_W'(1);
            done_d  = (IFG_BYTES == 1);
            state_d = S_IFG;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK125) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            pos_q      <= '0;
            sel_q      <= 1'b0;
            rr_q       <= 1'b0;
            TXD        <= 8'h00;
            TXEN       <= 1'b0;
            GNT        <= 2'b00;
            RD         <= 2'b00;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            pos_q      <= pos_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            TXD        <= txd_d;
            TXEN       <= txen_d;
            GNT        <= gnt_d;
            RD         <= rd_d;
            BUSY       <= busy_d;
            FRAME_DONE <= done_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: directed and randomized frames against a byte-stream model.
// Expected FCS bytes are included only when ETH_TX_FCS_EN is defined.
module tb_eth_tx_sched;

    localparam int PRE_N = 7;
    localparam int MIN_P = 60;
    localparam int MAX_P = 1500;
    localparam int IFG_N = 12;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [10:0] len0, len1;
    logic [7:0]  data0, data1;
    logic [1:0]  gnt, rd;
    logic [7:0]  txd;
    logic        txen, busy, frame_done;

    int checks   = 0;
    int failures = 0;
    int last_win = 1;
    int str0     = 0;
    int str1     = 0;
    logic [7:0] mem0 [2048];
    logic [7:0] mem1 [2048];

    eth_tx_sched dut (
        .CLK125     (clk),
        .RST        (rst),
        .REQ        (req),
        .LEN0       (len0),
        .LEN1       (len1),
        .DATA0      (data0),
        .DATA1      (data1),
        .GNT        (gnt),
        .RD         (rd),
        .TXD        (txd),
        .TXEN       (txen),
        .BUSY       (busy),
        .FRAME_DONE (frame_done)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sources present the byte at their read index and advance after each strobe.
    task automatic tick();
        @(posedge clk);
        #1;
        data0 = mem0[str0[10:0]];
        data1 = mem1[str1[10:0]];
        if (rd[0] === 1'b1) str0++;
        if (rd[1] === 1'b1) str1++;
    endtask

    // Round-robin reference: a lone requester wins, a tie goes to whoever did not win last.
    function automatic int model_win(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (last_win == 0) ? 1 : 0;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_txd"},  32'(txd), 32'h0);
        chk({tag, "_txen"}, 32'(txen), 32'h0);
        chk({tag, "_gnt"},  32'(gnt), 32'h0);
        chk({tag, "_rd"},   32'(rd), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(frame_done), 32'h0);
    endtask

    task automatic run_frame(input logic [1:0] r, input int l0, input int l1, input bit ramp,
                             input bit drop, input int exp_wait, output int won);
        int         len, n, other;
        logic [7:0] exp_q [$];
        logic [7:0] b;
        logic [31:0] crc;
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = ramp ? 8'(i) : 8'($urandom);
            mem1[i] = 8'($urandom);
        end
        str0 = 0;
        str1 = 0;
        len0 = 11'(l0);
        len1 = 11'(l1);
        req  = r;
        won  = model_win(r);
        last_win = won;
        len  = (won == 0) ? l0 : l1;
        if (len > MAX_P) len = MAX_P;

        n = 0;
        do begin
            tick();
            n++;
        end while (gnt === 2'b00 && n < 200);
        chk("gnt", 32'(gnt), (won == 0) ? 32'h1 : 32'h2);
        if (exp_wait != 0) chk("gnt_wait", 32'(n), 32'(exp_wait));
        if (gnt === 2'b00) return;
        chk("busy_start", 32'(busy), 32'h1);
        if (drop) req = 2'b00;

        for (int i = 0; i < PRE_N; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < len; k++) exp_q.push_back((won == 0) ? mem0[k] : mem1[k]);
        for (int k = len; k < MIN_P; k++) exp_q.push_back(8'h00);
`ifdef ETH_TX_FCS_EN
        crc = 32'hFFFFFFFF;
        for (int i = PRE_N + 1; i < exp_q.size(); i++) begin
            b = exp_q[i];
            for (int k = 0; k < 8; k++) begin
                if (crc[0] ^ b[k]) crc = (crc >> 1) ^ 32'hEDB88320;
                else               crc = crc >> 1;
            end
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(crc >> (8 * k)));
`else
        crc = 32'h0;
`endif

        for (int i = 0; i < exp_q.size(); i++) begin
            if (i != 0) tick();
            chk($sformatf("txen[%0d]", i), 32'(txen), 32'h1);
            chk($sformatf("txd[%0d]", i), 32'(txd), 32'(exp_q[i]));
            if (i == exp_q.size() - 1) chk("done_in_frame", 32'(frame_done), 32'h0);
        end
        for (int j = 1; j <= IFG_N; j++) begin
            tick();
            chk($sformatf("ifg_txen[%0d]", j), 32'(txen), 32'h0);
            chk($sformatf("ifg_txd[%0d]", j), 32'(txd), 32'h0);
            chk($sformatf("ifg_done[%0d]", j), 32'(frame_done), (j == IFG_N) ? 32'h1 : 32'h0);
            chk($sformatf("ifg_busy[%0d]", j), 32'(busy), 32'h1);
        end
        other = (won == 0) ? str1 : str0;
        chk("strobes", 32'((won == 0) ? str0 : str1), 32'(len));
        chk("other_strobes", 32'(other), 32'h0);
    endtask

    initial begin
        int won;
        int n;
        rst   = 1'b1;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;
        data0 = '0;
        data1 = '0;
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        repeat (3) tick();
        chk_reset_outputs("por");
        rst = 1'b0;

        // Ramp payload on requester 0, then a short padded frame on requester 1.
        run_frame(2'b01, 64, 0, 1'b1, 1'b1, 1, won);
        run_frame(2'b10, 0, 10, 1'b0, 1'b1, 2, won);

        // Both requesting continuously: grants must alternate starting with 0.
        for (int k = 0; k < 4; k++) begin
            run_frame(2'b11, $urandom_range(0, 70), $urandom_range(0, 70), 1'b0, 1'b0, 2, won);
            chk($sformatf("alternate[%0d]", k), 32'(won), 32'(k % 2));
        end

        // Length boundaries: empty payload and over-long clamp.
        run_frame(2'b01, 0, 5, 1'b0, 1'b1, 2, won);
        run_frame(2'b01, 2000, 0, 1'b0, 1'b1, 2, won);

        for (int k = 0; k < 6; k++) begin
            run_frame(2'($urandom_range(1, 3)), $urandom_range(0, 90), $urandom_range(0, 90),
                      1'b0, 1'b1, 2, won);
        end

        // Reset in the middle of the payload of a requester-0 frame.
        str0 = 0;
        str1 = 0;
        len0 = 11'd64;
        req  = 2'b01;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt === 2'b00 && n < 200);
        chk("mid_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        repeat (PRE_N + 1 + 20) tick();
        chk("mid_byte20", 32'(txd), 32'(mem0[20]));
        rst = 1'b1;
        tick();
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        last_win = 1;
        run_frame(2'b11, 30, 30, 1'b0, 1'b1, 1, won);
        chk("rr_after_reset", 32'(won), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
